sdram_arbiter: RTL and testbench

Arbiter and scheduler in front of the SDRAM sequencer. It shares the single SDRAM command sequencer between the Zorro III bus port, a local DMA port and periodic auto-refresh. It owns the refresh interval counter and a refresh-debt accumulator, so refresh can be postponed around bus bursts without ever being lost. It issues one-cycle start pulses to the sequencer and tracks the sequencer's busy handshake.

---
 rtl/sdram_arbiter.sv | 144 ++++++++++++++
 tb/tb_sdram_arbiter.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_arbiter.sv
// sdram_arbiter: shares the single SDRAM command sequencer between the Zorro III
// port, the local DMA port and periodic auto-refresh. Refresh credits accumulate
// as debt so refresh can be postponed around bus bursts without being lost.
module sdram_arbiter #(
  parameter int REFRESH_INTERVAL = 390,
  parameter int URGENT_DEBT      = 6,
  parameter int MAX_DEBT         = 8,
  parameter int DMA_STARVE       = 4
) (
  input  logic       CLK,
  input  logic       RESET_n,
  input  logic       init_done,
  input  logic       z_req,
  input  logic       dma_req,
  input  logic       seq_busy,
  output logic       start_access,
  output logic       start_refresh,
  output logic       z_gnt,
  output logic       dma_gnt,
  output logic       sel_dma,
  output logic [3:0] refresh_debt,
  output logic       refresh_overrun
);

  localparam int TW = (REFRESH_INTERVAL > 1) ? $clog2(REFRESH_INTERVAL) : 1;
  localparam logic [TW-1:0] RELOAD = TW'(REFRESH_INTERVAL - 1);
  localparam logic [3:0] URGENT = 4'(URGENT_DEBT);
  localparam logic [3:0] SAT    = 4'(MAX_DEBT);
  localparam logic [2:0] STARVE = 3'(DMA_STARVE);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] GUARD = 2'd1;
  localparam logic [1:0] RUN   = 2'd2;

  logic [1:0]    state;
  logic [TW-1:0] timer;
  logic [2:0]    starve;
  logic          credit;
  logic          pick_refresh;
  logic          pick_z;
  logic          pick_dma;

  // Priority decision taken only in IDLE once the SDRAM is initialised.
  always_comb begin
    credit       = init_done && (timer == '0);
    pick_refresh = 1'b0;
    pick_z       = 1'b0;
    pick_dma     = 1'b0;
    if (state == IDLE && init_done) begin
      if (refresh_debt >= URGENT) begin
        pick_refresh = 1'b1;
      end else if (dma_req && starve >= STARVE) begin
        pick_dma = 1'b1;
      end else if (z_req) begin
        pick_z = 1'b1;
      end else if (dma_req) begin
        pick_dma = 1'b1;
      end else if (refresh_debt != 4'd0) begin
        pick_refresh = 1'b1;
      end
    end
  end

  // Control FSM with registered one-cycle start/grant pulses and the mux steering level.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      state         <= IDLE;
      start_access  <= 1'b0;
      start_refresh <= 1'b0;
      z_gnt         <= 1'b0;
      dma_gnt       <= 1'b0;
      sel_dma       <= 1'b0;
    end else begin
      start_access  <= pick_z | pick_dma;
      start_refresh <= pick_refresh;
      z_gnt         <= pick_z;
      dma_gnt       <= pick_dma;
      case (state)
        IDLE: begin
          if (pick_z || pick_dma || pick_refresh) begin
            state   <= GUARD;
            sel_dma <= pick_dma;
          end
        end
        GUARD: begin
          state <= RUN;
        end
        RUN: begin
          if (!seq_busy) begin
            state   <= IDLE;
            sel_dma <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          sel_dma <= 1'b0;
        end
      endcase
    end
  end

  // Refresh interval timer: one credit each time it wraps, frozen until init is done.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      timer <= RELOAD;
    end else if (init_done) begin
      if (timer == '0) begin
        timer <= RELOAD;
      end else begin
        timer <= timer - 1'b1;
      end
    end
  end

  // Refresh debt accumulator with saturation and a sticky overrun flag for lost credits.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      refresh_debt    <= 4'd0;
      refresh_overrun <= 1'b0;
    end else begin
      if (credit && !pick_refresh) begin
        if (refresh_debt >= SAT) begin
          refresh_overrun <= 1'b1;
        end else begin
          refresh_debt <= refresh_debt + 4'd1;
        end
      end else if (!credit && pick_refresh) begin
        refresh_debt <= refresh_debt - 4'd1;
      end
    end
  end

  // Counts Zorro wins while DMA waits so DMA cannot be starved by a busy bus.
  always_ff @(posedge CLK or negedge RESET_n) begin
    if (!RESET_n) begin
      starve <= 3'd0;
    end else if (pick_dma || !dma_req) begin
      starve <= 3'd0;
    end else if (pick_z && starve != 3'd7) begin
      starve <= starve + 3'd1;
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// tb_sdram_arbiter: directed scenarios with a scoreboard of expected start pulses
// (kind and cycle after reset release) and a behavioural sequencer model.
module tb_sdram_arbiter;

  localparam int K_Z   = 0;
  localparam int K_DMA = 1;
  localparam int K_REF = 2;

  logic       CLK = 1'b0;
  logic       RESET_n = 1'b0;
  logic       init_done = 1'b0;
  logic       z_req = 1'b0;
  logic       dma_req = 1'b0;
  logic       seq_busy = 1'b0;
  logic       start_access;
  logic       start_refresh;
  logic       z_gnt;
  logic       dma_gnt;
  logic       sel_dma;
  logic [3:0] refresh_debt;
  logic       refresh_overrun;

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int base = 0;
  int access_busy = 1;
  int refresh_busy = 1;
  int busy_cnt = 0;
  bit sel_pending = 1'b0;
  int sel_owner = 0;

  typedef struct {
    int kind;
    int at;
  } exp_t;

  exp_t exp_q[$];

  sdram_arbiter #(
    .REFRESH_INTERVAL(16),
    .URGENT_DEBT(6),
    .MAX_DEBT(8),
    .DMA_STARVE(4)
  ) dut (
    .CLK(CLK),
    .RESET_n(RESET_n),
    .init_done(init_done),
    .z_req(z_req),
    .dma_req(dma_req),
    .seq_busy(seq_busy),
    .start_access(start_access),
    .start_refresh(start_refresh),
    .z_gnt(z_gnt),
    .dma_gnt(dma_gnt),
    .sel_dma(sel_dma),
    .refresh_debt(refresh_debt),
    .refresh_overrun(refresh_overrun)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) cyc <= cyc + 1;

  task automatic check_output(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%0d expected=%0d at rel=%0d", name, actual, expected, cyc - base);
    end
  endtask

  task automatic expect_pulse(input int kind, input int at);
    exp_t e;
    e.kind = kind;
    e.at   = at;
    exp_q.push_back(e);
  endtask

  task automatic wait_rel(input int r);
    while (cyc - base < r) @(negedge CLK);
  endtask

  task automatic check_queue();
    check_output("queue_drained", exp_q.size(), 0);
    exp_q.delete();
  endtask

  task automatic check_reset_values();
    check_output("rst_start_access", int'(start_access), 0);
    check_output("rst_start_refresh", int'(start_refresh), 0);
    check_output("rst_z_gnt", int'(z_gnt), 0);
    check_output("rst_dma_gnt", int'(dma_gnt), 0);
    check_output("rst_sel_dma", int'(sel_dma), 0);
    check_output("rst_refresh_debt", int'(refresh_debt), 0);
    check_output("rst_refresh_overrun", int'(refresh_overrun), 0);
  endtask

  task automatic do_reset(input bit init, input bit zr, input bit dr);
    RESET_n   = 1'b0;
    z_req     = 1'b0;
    dma_req   = 1'b0;
    init_done = 1'b0;
    repeat (2) @(negedge CLK);
    init_done = init;
    z_req     = zr;
    dma_req   = dr;
    RESET_n   = 1'b1;
    base      = cyc;
  endtask

  // Sequencer model: busy for a programmable number of cycles after each start pulse.
  always @(negedge CLK) begin
    if (!RESET_n) busy_cnt = 0;
    else if (start_access) busy_cnt = access_busy;
    else if (start_refresh) busy_cnt = refresh_busy;
    else if (busy_cnt > 0) busy_cnt = busy_cnt - 1;
    seq_busy = (busy_cnt > 0);
  end

  // Monitor: every start pulse pops one expected entry and is compared against it.
  always @(negedge CLK) begin
    int act;
    int rel;
    exp_t e;
    if (RESET_n) begin
      rel = cyc - base;
      if (sel_pending) begin
        sel_pending = 1'b0;
        check_output("sel_in_run", int'(sel_dma), sel_owner);
      end
      if (start_access || start_refresh || z_gnt || dma_gnt) begin
        if (start_refresh && !start_access && !z_gnt && !dma_gnt) act = K_REF;
        else if (start_access && z_gnt && !dma_gnt && !start_refresh) act = K_Z;
        else if (start_access && dma_gnt && !z_gnt && !start_refresh) act = K_DMA;
        else act = 3;
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("[TB] FAIL unexpected_pulse kind=%0d rel=%0d expected=none", act, rel);
        end else begin
          e = exp_q.pop_front();
          checks++;
          if (act != e.kind || rel != e.at) begin
            failures++;
            $display("[TB] FAIL pulse kind=%0d rel=%0d expected kind=%0d rel=%0d", act, rel, e.kind, e.at);
          end
        end
        if (act == K_Z || act == K_DMA) begin
          check_output("sel_at_grant", int'(sel_dma), (act == K_DMA) ? 1 : 0);
          sel_pending = 1'b1;
          sel_owner   = (act == K_DMA) ? 1 : 0;
        end
      end
    end
  end

  initial begin
    // Reset state, then init_done low with z_req held: nothing may happen.
    repeat (3) @(negedge CLK);
    check_reset_values();
    do_reset(1'b0, 1'b1, 1'b0);
    wait_rel(1000);
    check_output("noinit_debt", int'(refresh_debt), 0);
    check_output("noinit_overrun", int'(refresh_overrun), 0);
    check_queue();

    // Single Zorro access with 6-cycle busy, request held over two grants.
    access_busy  = 6;
    refresh_busy = 6;
    do_reset(1'b1, 1'b1, 1'b0);
    expect_pulse(K_Z, 1);
    expect_pulse(K_Z, 9);
    expect_pulse(K_REF, 17);
    wait_rel(9);
    z_req = 1'b0;
    wait_rel(16);
    check_output("b_debt_credit", int'(refresh_debt), 1);
    wait_rel(17);
    check_output("b_debt_after_ref", int'(refresh_debt), 0);
    wait_rel(30);
    check_queue();

    // Idle refresh cadence: one refresh per interval, debt toggles 0/1.
    refresh_busy = 4;
    do_reset(1'b1, 1'b0, 1'b0);
    expect_pulse(K_REF, 17);
    expect_pulse(K_REF, 33);
    expect_pulse(K_REF, 49);
    expect_pulse(K_REF, 65);
    wait_rel(16);
    check_output("c_debt_16", int'(refresh_debt), 1);
    wait_rel(17);
    check_output("c_debt_17", int'(refresh_debt), 0);
    wait_rel(32);
    check_output("c_debt_32", int'(refresh_debt), 1);
    wait_rel(33);
    check_output("c_debt_33", int'(refresh_debt), 0);
    wait_rel(70);
    check_output("c_overrun", int'(refresh_overrun), 0);
    check_queue();

    // Long Zorro accesses: debt climbs until urgent refresh preempts z_req.
    access_busy  = 40;
    refresh_busy = 4;
    do_reset(1'b1, 1'b1, 1'b0);
    expect_pulse(K_Z, 1);
    expect_pulse(K_Z, 43);
    expect_pulse(K_Z, 85);
    expect_pulse(K_REF, 127);
    expect_pulse(K_REF, 133);
    expect_pulse(K_REF, 139);
    expect_pulse(K_REF, 145);
    expect_pulse(K_Z, 151);
    wait_rel(126);
    check_output("d_debt_126", int'(refresh_debt), 7);
    wait_rel(127);
    check_output("d_debt_127", int'(refresh_debt), 6);
    wait_rel(150);
    check_output("d_debt_150", int'(refresh_debt), 5);
    wait_rel(160);
    check_queue();

    // Busy held 200 cycles: debt saturates at 8 and overrun becomes sticky.
    access_busy  = 200;
    refresh_busy = 4;
    do_reset(1'b1, 1'b1, 1'b0);
    expect_pulse(K_Z, 1);
    expect_pulse(K_REF, 203);
    wait_rel(127);
    check_output("e_debt_127", int'(refresh_debt), 7);
    wait_rel(128);
    check_output("e_debt_128", int'(refresh_debt), 8);
    check_output("e_overrun_128", int'(refresh_overrun), 0);
    wait_rel(143);
    check_output("e_overrun_143", int'(refresh_overrun), 0);
    wait_rel(144);
    check_output("e_debt_144", int'(refresh_debt), 8);
    check_output("e_overrun_144", int'(refresh_overrun), 1);
    wait_rel(204);
    check_output("e_debt_204", int'(refresh_debt), 7);
    check_output("e_overrun_204", int'(refresh_overrun), 1);
    wait_rel(206);
    check_queue();

    // Both requesters held with short busy: DMA wins after four Zorro grants.
    access_busy  = 1;
    refresh_busy = 1;
    do_reset(1'b1, 1'b1, 1'b1);
    expect_pulse(K_Z, 1);
    expect_pulse(K_Z, 4);
    expect_pulse(K_Z, 7);
    expect_pulse(K_Z, 10);
    expect_pulse(K_DMA, 13);
    expect_pulse(K_Z, 16);
    expect_pulse(K_Z, 19);
    expect_pulse(K_Z, 22);
    expect_pulse(K_Z, 25);
    expect_pulse(K_DMA, 28);
    expect_pulse(K_REF, 31);
    expect_pulse(K_REF, 34);
    wait_rel(28);
    z_req   = 1'b0;
    dma_req = 1'b0;
    wait_rel(40);
    check_output("f_debt_40", int'(refresh_debt), 0);
    check_queue();

    // Reset during a DMA access with debt 3; nothing follows until a new request.
    access_busy = 60;
    do_reset(1'b1, 1'b0, 1'b1);
    expect_pulse(K_DMA, 1);
    wait_rel(50);
    check_output("g_debt_50", int'(refresh_debt), 3);
    check_output("g_sel_50", int'(sel_dma), 1);
    check_queue();
    RESET_n = 1'b0;
    dma_req = 1'b0;
    #1;
    check_reset_values();
    access_busy = 2;
    do_reset(1'b1, 1'b0, 1'b0);
    wait_rel(10);
    expect_pulse(K_Z, 11);
    z_req = 1'b1;
    wait_rel(11);
    z_req = 1'b0;
    wait_rel(14);
    check_queue();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
